// File: rtl/clock_reconfig_sequencer.sv
// Clock reconfiguration sequencer: gen DCM reprogram + lock, ADC DCM reset + lock, phase reload.
// Optional sticky lock monitor is built only when CLKSEQ_LOCKMON_EN is defined.
module clock_reconfig_sequencer #(
  parameter int         RST_CYCLES     = 8,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] DEF_MUL        = 8'd2,
  parameter logic [7:0] DEF_DIV        = 8'd2
) (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic       req_i,
  input  logic [2:0] new_adc_source_i,
  input  logic       new_gen_source_i,
  input  logic [7:0] new_mul_i,
  input  logic [7:0] new_div_i,
  input  logic [8:0] new_phase_i,
  output logic [2:0] clkadc_source_o,
  output logic       clkgen_source_o,
  output logic [7:0] clkgen_mul_o,
  output logic [7:0] clkgen_div_o,
  output logic [8:0] phase_requested_o,
  output logic       clkgen_reset_o,
  output logic       dcm_reset_o,
  output logic       clkgen_load_o,
  output logic       phase_load_o,
  input  logic       clkgen_done_i,
  input  logic       phase_done_i,
  input  logic       dcm_gen_locked_i,
  input  logic       dcm_adc_locked_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [2:0] err_code_o,
  output logic       lock_lost_o,
  output logic [2:0] dbg_state
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] IGNORE   = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN_RST, S_GEN_LOAD, S_GEN_LOCK, S_ADC_RST, S_ADC_LOCK, S_PHASE, S_FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    cap_adc;
  logic [8:0]    cap_phase;

  assign dbg_state = state;

  // Handshake: req_i is a level sampled only in IDLE (busy requests are dropped);
  // done/lock inputs are levels, and cnt is the cycle index since entering the current state.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      cap_adc           <= '0;
      cap_phase         <= '0;
      clkadc_source_o   <= '0;
      clkgen_source_o   <= 1'b0;
      clkgen_mul_o      <= DEF_MUL;
      clkgen_div_o      <= DEF_DIV;
      phase_requested_o <= '0;
      clkgen_reset_o    <= 1'b0;
      dcm_reset_o       <= 1'b0;
      clkgen_load_o     <= 1'b0;
      phase_load_o      <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
      err_code_o        <= '0;
    end else begin
      clkgen_load_o <= 1'b0;
      phase_load_o  <= 1'b0;
      done_o        <= 1'b0;
      cnt           <= cnt + CW'(1);
      case (state)
        S_IDLE: begin
          if (req_i) begin
            cap_adc         <= new_adc_source_i;
            cap_phase       <= new_phase_i;
            clkgen_source_o <= new_gen_source_i;
            clkgen_mul_o    <= new_mul_i;
            clkgen_div_o    <= new_div_i;
            clkgen_reset_o  <= 1'b1;
            busy_o          <= 1'b1;
            error_o         <= 1'b0;
            err_code_o      <= '0;
            cnt             <= '0;
            state           <= S_GEN_RST;
          end
        end
        S_GEN_RST: begin
          if (cnt == RST_LAST) begin
            clkgen_reset_o <= 1'b0;
            clkgen_load_o  <= 1'b1;
            cnt            <= '0;
            state          <= S_GEN_LOAD;
          end
        end
        S_GEN_LOAD: begin
          // The load engine needs two cycles before its done level is meaningful.
          if (cnt >= IGNORE && clkgen_done_i) begin
            cnt   <= '0;
            state <= S_GEN_LOCK;
          end else if (cnt == TO_LAST) begin
            error_o    <= 1'b1;
            err_code_o <= 3'd1;
            state      <= S_FIN;
          end
        end
        S_GEN_LOCK: begin
          if (dcm_gen_locked_i) begin
            clkadc_source_o <= cap_adc;
            dcm_reset_o     <= 1'b1;
            cnt             <= '0;
            state           <= S_ADC_RST;
          end else if (cnt == TO_LAST) begin
            error_o    <= 1'b1;
            err_code_o <= 3'd2;
            state      <= S_FIN;
          end
        end
        S_ADC_RST: begin
          if (cnt == RST_LAST) begin
            dcm_reset_o <= 1'b0;
            cnt         <= '0;
            state       <= S_ADC_LOCK;
          end
        end
        S_ADC_LOCK: begin
          if (dcm_adc_locked_i) begin
            phase_requested_o <= cap_phase;
            phase_load_o      <= 1'b1;
            cnt               <= '0;
            state             <= S_PHASE;
          end else if (cnt == TO_LAST) begin
            error_o    <= 1'b1;
            err_code_o <= 3'd3;
            state      <= S_FIN;
          end
        end
        S_PHASE: begin
          if (cnt >= IGNORE && phase_done_i) begin
            state <= S_FIN;
          end else if (cnt == TO_LAST) begin
            error_o    <= 1'b1;
            err_code_o <= 3'd4;
            state      <= S_FIN;
          end
        end
        S_FIN: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CLKSEQ_LOCKMON_EN
  logic armed;

  // Armed only by a successful sequence; a failure disarms until the next success.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      armed       <= 1'b0;
      lock_lost_o <= 1'b0;
    end else begin
      if (state == S_FIN) armed <= ~error_o;
      if (state == S_IDLE && req_i) lock_lost_o <= 1'b0;
      else if (state == S_IDLE && armed && !(dcm_adc_locked_i && dcm_gen_locked_i)) lock_lost_o <= 1'b1;
    end
  end
`else
  assign lock_lost_o = 1'b0;
`endif

endmodule
